bip2_control: RTL and testbench
===============================

Name: bip2_control

Overview:
- Instruction-sequencing control unit for the BIP-2 core.
- Fetches 16-bit instructions from program memory, decodes them, and drives the datapath controls: selA, selB, WRACC, op, operand.
- Drives data-memory write enable and evaluates conditional branches from registered Z/N flags.
- Sits between program ROM and the datapath; it is the initiator end of the datapath control interface.

Parameters:
- MSB_DATA, 16, instruction word width.
- MSB_OPERAND, 11, operand field width (instr[10:0]).
- MSB_OPCODE, 5, opcode field width (instr[15:11]).
- MSB_ROM, 11, program-counter / program-memory address width.
- MSB_SELA, 2, selA width.
- RESET_PC, 0, PC value after reset.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- im_data_i  in  MSB_DATA  program-memory read data; synchronous ROM, valid 1 cycle after im_addr_o.
- flagZ_i  in  1  datapath zero flag.
- flagN_i  in  1  datapath negative flag.
- im_addr_o  out  MSB_ROM  program counter / ROM address.
- selA_o  out  MSB_SELA  accumulator source: 00 dm_out_data, 01 extended operand, 10 ULA result.
- selB_o  out  1  ULA operand2: 0 dm_out_data, 1 extended operand.
- wracc_o  out  1  accumulator write strobe.
- op_o  out  1  ULA operation: 0 add, 1 sub.
- operand_o  out  MSB_OPERAND  IR[10:0]; also the data-memory address.
- wrram_o  out  1  data-memory write strobe (store ACC).
- halted_o  out  1  core halted.

Behaviour:
- Reset (synchronous): state=FETCH, PC=RESET_PC, IR=0, Zr=0, Nr=0, all outputs 0. Reset asserted in any state aborts the instruction in progress; no strobe fires in the reset cycle.
- FSM: FETCH -> DECODE -> EXEC -> FETCH. HALT is sticky until reset.
- Every instruction takes 3 cycles.
- FETCH: im_addr_o=PC.
- DECODE: IR<=im_data_i. operand_o follows IR from the next cycle, so synchronous data-memory read data is valid during EXEC.
- EXEC: drive the controls below for exactly one cycle; wracc_o/wrram_o are single-cycle pulses. PC is updated at the end of EXEC.
- Opcodes (IR[15:11]) and EXEC controls:
  - 00 HLT: state->HALT; halted_o=1 from the next cycle; PC is not incremented.
  - 01 STO: wrram_o=1.
  - 02 LD: selA=00, wracc=1.
  - 03 LDI: selA=01, wracc=1.
  - 04 ADD: selA=10, selB=0, op=0, wracc=1.
  - 05 ADDI: selA=10, selB=1, op=0, wracc=1.
  - 06 SUB: selA=10, selB=0, op=1, wracc=1.
  - 07 SUBI: selA=10, selB=1, op=1, wracc=1.
  - 08 BEQ: taken if Zr.
  - 09 BNE: taken if !Zr.
  - 0A BGT: taken if !Zr & !Nr.
  - 0B BGE: taken if !Nr.
  - 0C BLT: taken if Nr.
  - 0D BLE: taken if Nr | Zr.
  - 0E JMP: unconditional.
  - 0F–1F: NOP.
- Flags: Zr<=flagZ_i and Nr<=flagN_i are captured at the end of EXEC for ADD/ADDI/SUB/SUBI only. LD, LDI and branches leave the flags unchanged.
- PC: a taken branch or JMP loads PC<=IR[MSB_ROM-1:0]; otherwise PC<=PC+1, wrapping from 2^MSB_ROM-1 to 0.
- Outside EXEC: selA_o=00, selB_o=0, op_o=0, wracc_o=0, wrram_o=0. operand_o holds IR.
- HALT: im_addr_o holds the HLT address, all strobes stay 0, inputs are ignored.

Optional Feature:
- Macro: BIP2_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 0F–1F enter HALT instead of executing as NOP.
  - Extra port illegal_o (out, 1) is set with halted_o and stays set until reset.
  - PC holds the address of the offending instruction.
- Undefined: opcodes 0F–1F are NOP and port illegal_o does not exist.

Test Plan:
- Reset then release; ROM[0]=LDI 5 (0x1805) -> im_addr_o=0 in cycle 1; EXEC in cycle 3 with selA_o=01, wracc_o=1 for 1 cycle, operand_o=0x005; im_addr_o=1 in cycle 4.
- ROM: ADDI 3, then SUB with operand 0x010 -> ADDI EXEC: selB=1, op=0; SUB EXEC: selB=0, op=1, operand_o=0x010 from its DECODE+1 cycle onward.
- SUBI with flagZ_i=1 at EXEC, then BEQ 0x020 -> PC=0x020. Repeat with flagZ_i=0 -> PC=branch address+1. Branch after LDI must not change flags.
- BLE at PC=0x7FF not taken (Nr=0, Zr=0) -> PC wraps to 0x000. JMP 0x7FF -> PC=0x7FF.
- HLT at address 4 -> halted_o=1, im_addr_o stays 4 for 20 cycles, no strobes. reset_i pulsed -> PC=0, halted_o=0.
- reset_i asserted during EXEC of STO -> wrram_o stays 0 that cycle; next cycle state=FETCH, PC=0. With BIP2_ILLEGAL_TRAP_EN: opcode 0x12 -> halted_o=1, illegal_o=1.

Source files
------------

// File: rtl/bip2_control.sv
// +----------------------------------------------------------------------------+
// | Module      : bip2_control                                                 |
// | Description : BIP-2 fetch/decode/execute sequencer driving datapath        |
// |               controls, data-memory write and conditional branching.       |
// |               Optional macro BIP2_ILLEGAL_TRAP_EN traps opcodes 0F-1F.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bip2_control #(
  parameter int MSB_DATA    = 16,
  parameter int MSB_OPERAND = 11,
  parameter int MSB_OPCODE  = 5,
  parameter int MSB_ROM     = 11,
  parameter int MSB_SELA    = 2,
  parameter int RESET_PC    = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [MSB_DATA-1:0]    im_data_i,
  input  logic                   flagZ_i,
  input  logic                   flagN_i,
  output logic [MSB_ROM-1:0]     im_addr_o,
  output logic [MSB_SELA-1:0]    selA_o,
  output logic                   selB_o,
  output logic                   wracc_o,
  output logic                   op_o,
  output logic [MSB_OPERAND-1:0] operand_o,
  output logic                   wrram_o,
`ifdef BIP2_ILLEGAL_TRAP_EN
  output logic                   illegal_o,
`endif
  output logic                   halted_o
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [MSB_OPCODE-1:0] OP_HLT  = MSB_OPCODE'(5'h00);
  localparam logic [MSB_OPCODE-1:0] OP_STO  = MSB_OPCODE'(5'h01);
  localparam logic [MSB_OPCODE-1:0] OP_LD   = MSB_OPCODE'(5'h02);
  localparam logic [MSB_OPCODE-1:0] OP_LDI  = MSB_OPCODE'(5'h03);
  localparam logic [MSB_OPCODE-1:0] OP_ADD  = MSB_OPCODE'(5'h04);
  localparam logic [MSB_OPCODE-1:0] OP_ADDI = MSB_OPCODE'(5'h05);
  localparam logic [MSB_OPCODE-1:0] OP_SUB  = MSB_OPCODE'(5'h06);
  localparam logic [MSB_OPCODE-1:0] OP_SUBI = MSB_OPCODE'(5'h07);
  localparam logic [MSB_OPCODE-1:0] OP_BEQ  = MSB_OPCODE'(5'h08);
  localparam logic [MSB_OPCODE-1:0] OP_BNE  = MSB_OPCODE'(5'h09);
  localparam logic [MSB_OPCODE-1:0] OP_BGT  = MSB_OPCODE'(5'h0A);
  localparam logic [MSB_OPCODE-1:0] OP_BGE  = MSB_OPCODE'(5'h0B);
  localparam logic [MSB_OPCODE-1:0] OP_BLT  = MSB_OPCODE'(5'h0C);
  localparam logic [MSB_OPCODE-1:0] OP_BLE  = MSB_OPCODE'(5'h0D);
  localparam logic [MSB_OPCODE-1:0] OP_JMP  = MSB_OPCODE'(5'h0E);

  localparam logic [MSB_ROM-1:0]  C_RESET_PC = MSB_ROM'(RESET_PC);
  localparam logic [MSB_SELA-1:0] C_SELA_DM  = MSB_SELA'(2'b00);
  localparam logic [MSB_SELA-1:0] C_SELA_IMM = MSB_SELA'(2'b01);
  localparam logic [MSB_SELA-1:0] C_SELA_ULA = MSB_SELA'(2'b10);

  state_t                state_q, state_d;
  logic [MSB_ROM-1:0]    pc_q, pc_d;
  logic [MSB_DATA-1:0]   ir_q, ir_d;
  logic                  zr_q, zr_d;
  logic                  nr_q, nr_d;
  logic                  illegal_q, illegal_d;

  logic [MSB_OPCODE-1:0] opcode_w;
  logic                  taken_w;
  logic [MSB_SELA-1:0]   sela_w;
  logic                  selb_w;
  logic                  op_w;
  logic                  wracc_w;
  logic                  wrram_w;

  assign opcode_w = ir_q[MSB_DATA-1 -: MSB_OPCODE];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      pc_q      <= C_RESET_PC;
      ir_q      <= '0;
      zr_q      <= 1'b0;
      nr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      zr_q      <= zr_d;
      nr_q      <= nr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    taken_w = 1'b0;
    case (opcode_w)
      OP_BEQ:  taken_w = zr_q;
      OP_BNE:  taken_w = ~zr_q;
      OP_BGT:  taken_w = ~zr_q & ~nr_q;
      OP_BGE:  taken_w = ~nr_q;
      OP_BLT:  taken_w = nr_q;
      OP_BLE:  taken_w = nr_q | zr_q;
      OP_JMP:  taken_w = 1'b1;
      default: taken_w = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    zr_d      = zr_q;
    nr_d      = nr_q;
    illegal_d = illegal_q;
    sela_w    = '0;
    selb_w    = 1'b0;
    op_w      = 1'b0;
    wracc_w   = 1'b0;
    wrram_w   = 1'b0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = im_data_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = taken_w ? ir_q[MSB_ROM-1:0] : pc_q + MSB_ROM'(1);
        case (opcode_w)
          OP_HLT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          OP_STO: wrram_w = 1'b1;
          OP_LD: begin
            sela_w  = C_SELA_DM;
            wracc_w = 1'b1;
          end
          OP_LDI: begin
            sela_w  = C_SELA_IMM;
            wracc_w = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sela_w  = C_SELA_ULA;
            selb_w  = opcode_w[0];
            op_w    = opcode_w[1];
            wracc_w = 1'b1;
            zr_d    = flagZ_i;
            nr_d    = flagN_i;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: ;
          default: begin
`ifdef BIP2_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            pc_d      = pc_q;
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A reset landing mid-EXEC must not let a strobe escape in that cycle.
    if (reset_i) begin
      sela_w  = '0;
      selb_w  = 1'b0;
      op_w    = 1'b0;
      wracc_w = 1'b0;
      wrram_w = 1'b0;
    end
  end

  assign im_addr_o = pc_q;
  assign operand_o = ir_q[MSB_OPERAND-1:0];
  assign selA_o    = sela_w;
  assign selB_o    = selb_w;
  assign op_o      = op_w;
  assign wracc_o   = wracc_w;
  assign wrram_o   = wrram_w;
  assign halted_o  = (state_q == S_HALT);
`ifdef BIP2_ILLEGAL_TRAP_EN
  assign illegal_o = illegal_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bip2_control.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bip2_control                                              |
// | Description : Scoreboard bench for bip2_control with a small BIP-2         |
// |               datapath and ROM around it.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bip2_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] im_data;
  logic        fz, fn;
  logic [10:0] im_addr;
  logic [1:0]  selA;
  logic        selB, wracc, op, wrram, halted;
  logic [10:0] operand;
`ifdef BIP2_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  bip2_control dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .im_data_i (im_data),
    .flagZ_i   (fz),
    .flagN_i   (fn),
    .im_addr_o (im_addr),
    .selA_o    (selA),
    .selB_o    (selB),
    .wracc_o   (wracc),
    .op_o      (op),
    .operand_o (operand),
    .wrram_o   (wrram),
`ifdef BIP2_ILLEGAL_TRAP_EN
    .illegal_o (illegal),
`endif
    .halted_o  (halted)
  );

  // Program ROM (synchronous) and a minimal accumulator datapath.
  logic [15:0] rom [0:2047];
  logic [15:0] dm  [0:2047];
  logic [15:0] acc, ext, dmo, opb, ula;

  always @(posedge clk) im_data <= rom[im_addr];

  always_comb begin
    ext = {{5{operand[10]}}, operand};
    dmo = dm[operand];
    opb = selB ? ext : dmo;
    ula = op ? (acc - opb) : (acc + opb);
  end
  assign fz = (ula == 16'h0000);
  assign fn = ula[15];

  always @(posedge clk) begin
    if (rst) begin
      acc <= 16'h0000;
      for (int i = 0; i < 2048; i++) dm[i] <= 16'h0000;
    end else begin
      if (wracc) acc <= (selA == 2'b00) ? dmo : (selA == 2'b01) ? ext : ula;
      if (wrram) dm[operand] <= acc;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [16:0] ctl(input logic [1:0] sa, input logic sb, input logic o,
                                      input logic wa, input logic wr, input logic [10:0] opd);
    return {sa, sb, o, wa, wr, opd};
  endfunction

  logic [16:0] ctl_q [$];
  logic [10:0] addr_q [$];
  logic [10:0] prev_addr = 11'h000;
  bit          mon_en = 1'b0;

  // Monitor: pops an expected control word for every strobe and an expected
  // address for every change of im_addr_o.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wracc || wrram) begin
        if (ctl_q.size() == 0) begin
          n_chk++;
          $display("FAIL ctl_unexpected: got strobe wracc=%0b wrram=%0b expected none at %0t",
                   wracc, wrram, $time);
        end else begin
          chk("ctl_exec", 32'({selA, selB, op, wracc, wrram, operand}), 32'(ctl_q.pop_front()));
        end
      end else begin
        chk("ctl_idle", 32'({selA, selB, op}), 32'd0);
      end
      if (im_addr != prev_addr) begin
        if (addr_q.size() == 0) begin
          n_chk++;
          $display("FAIL addr_unexpected: got 0x%0h expected 0x%0h at %0t", im_addr, prev_addr, $time);
        end else begin
          chk("addr_seq", 32'(im_addr), 32'(addr_q.pop_front()));
        end
        prev_addr = im_addr;
      end
    end
  end

  task automatic wait_addr(input logic [10:0] a, input int budget);
    int k = 0;
    while (im_addr !== a && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_addr", 32'(im_addr), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    rom[11'h000] = 16'h1805;  // LDI 5
    rom[11'h001] = 16'h2803;  // ADDI 3   -> 8
    rom[11'h002] = 16'h0810;  // STO 0x10
    rom[11'h003] = 16'h3010;  // SUB 0x10 -> 0, Z
    rom[11'h004] = 16'h4020;  // BEQ 0x20 taken
    rom[11'h020] = 16'h1810;  // LDI 0x10 (flags kept)
    rom[11'h021] = 16'h4030;  // BEQ 0x30 taken
    rom[11'h030] = 16'h3803;  // SUBI 3   -> 13
    rom[11'h031] = 16'h4040;  // BEQ not taken
    rom[11'h032] = 16'h4840;  // BNE 0x40 taken
    rom[11'h040] = 16'h3810;  // SUBI 16  -> -3, N
    rom[11'h041] = 16'h5850;  // BGE not taken
    rom[11'h042] = 16'h6050;  // BLT 0x50 taken
    rom[11'h050] = 16'h5060;  // BGT not taken
    rom[11'h051] = 16'h2803;  // ADDI 3   -> 0, Z
    rom[11'h052] = 16'h6860;  // BLE 0x60 taken
    rom[11'h060] = 16'h2801;  // ADDI 1   -> 1
    rom[11'h061] = 16'h77FF;  // JMP 0x7FF
    rom[11'h7FF] = 16'h6900;  // BLE not taken -> wrap

    ctl_q.push_back(ctl(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 11'h005));
    ctl_q.push_back(ctl(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 11'h003));
    ctl_q.push_back(ctl(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 11'h010));
    ctl_q.push_back(ctl(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 11'h010));
    ctl_q.push_back(ctl(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 11'h010));
    ctl_q.push_back(ctl(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 11'h003));
    ctl_q.push_back(ctl(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 11'h010));
    ctl_q.push_back(ctl(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 11'h003));
    ctl_q.push_back(ctl(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 11'h001));

    foreach (addr_q[i]) addr_q.delete(i);
    addr_q.push_back(11'h001); addr_q.push_back(11'h002); addr_q.push_back(11'h003);
    addr_q.push_back(11'h004); addr_q.push_back(11'h020); addr_q.push_back(11'h021);
    addr_q.push_back(11'h030); addr_q.push_back(11'h031); addr_q.push_back(11'h032);
    addr_q.push_back(11'h040); addr_q.push_back(11'h041); addr_q.push_back(11'h042);
    addr_q.push_back(11'h050); addr_q.push_back(11'h051); addr_q.push_back(11'h052);
    addr_q.push_back(11'h060); addr_q.push_back(11'h061); addr_q.push_back(11'h7FF);
    addr_q.push_back(11'h000); addr_q.push_back(11'h004);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr",    32'(im_addr), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_halted",  32'(halted),  32'd0);
    chk("rst_strobes", 32'({wracc, wrram, selA, selB, op}), 32'd0);
    mon_en = 1'b1;
    rst    = 1'b0;

    // First instruction: EXEC lands in the third cycle, for one cycle only.
    @(negedge clk);
    @(negedge clk);
    chk("ldi_exec_wracc", 32'(wracc), 32'd1);
    chk("ldi_exec_opnd",  32'(operand), 32'h005);
    @(negedge clk);
    chk("ldi_pulse_end",  32'(wracc), 32'd0);
    chk("ldi_next_addr",  32'(im_addr), 32'd1);

    wait_addr(11'h7FF, 300);
    rom[11'h000] = 16'h7004;  // JMP 4
    rom[11'h004] = 16'h0000;  // HLT
    wait_addr(11'h004, 30);
    repeat (4) @(negedge clk);
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_addr_hold", 32'(im_addr), 32'h004);
    end
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reset out of HALT, then abort a STO in its EXEC cycle.
    rom[11'h000] = 16'h0805;  // STO 5
    addr_q.push_back(11'h000);
    rst = 1'b1;
    @(negedge clk);
    chk("unhalt", 32'(halted), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("sto_abort_wrram", 32'(wrram), 32'd0);
    @(negedge clk);
    chk("sto_abort_addr",    32'(im_addr), 32'd0);
    chk("sto_abort_operand", 32'(operand), 32'd0);
    chk("sto_abort_halted",  32'(halted),  32'd0);

    // Opcode 0x12: NOP by default, trap when the feature is built in.
    rom[11'h000] = 16'h9000;
    rom[11'h001] = 16'h0000;
`ifndef BIP2_ILLEGAL_TRAP_EN
    addr_q.push_back(11'h001);
`endif
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("op12_halted", 32'(halted), 32'd1);
`ifdef BIP2_ILLEGAL_TRAP_EN
    chk("op12_addr",    32'(im_addr), 32'h000);
    chk("op12_illegal", 32'(illegal), 32'd1);
`else
    chk("op12_addr",    32'(im_addr), 32'h001);
`endif

    repeat (2) @(negedge clk);
    chk("ctl_q_drained",  32'(ctl_q.size()),  32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
